// File: rtl/lfsr_gen_pkg.sv
// lfsr_gen_pkg: shared types and default tap masks for the lfsr_gen slice.
package lfsr_gen_pkg;

  // Request-handling FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } lfsr_state_e;

  // Tap masks used when an instantiation does not override TAPS
  localparam logic [31:0] TAPS_W8  = 32'h0000_001C;
  localparam logic [31:0] TAPS_W12 = 32'h0000_0050;
  localparam logic [31:0] TAPS_W16 = 32'h0000_2D00;
  localparam logic [31:0] TAPS_W24 = 32'h0000_0086;
  localparam logic [31:0] TAPS_W32 = 32'h0000_0062;

  // Pick the default tap mask for a given state width; other widths fall
  // back to a single tap one below the MSB.
  function automatic logic [31:0] default_taps(input int width);
    case (width)
      8:       return TAPS_W8;
      12:      return TAPS_W12;
      16:      return TAPS_W16;
      24:      return TAPS_W24;
      32:      return TAPS_W32;
      default: return 32'h1 << (width - 2);
    endcase
  endfunction

endpackage

// File: rtl/lfsr_gen_step.sv
// lfsr_step: one combinational Galois step with XNOR feedback. The MSB
// rotates into bit 0; every tapped bit takes the XNOR of its lower
// neighbour and the MSB, untapped bits simply shift up.
module lfsr_step
  import lfsr_gen_pkg::*;
#(
  parameter int               WIDTH = 12,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH))
) (
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nxt
);

  // Next-state computation, bit by bit
  always_comb begin
    nxt    = '0;
    nxt[0] = q[WIDTH-1];
    for (int i = 1; i < WIDTH; i++) begin
      nxt[i] = TAPS[i] ? ~(q[i-1] ^ q[WIDTH-1]) : q[i-1];
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: free-running Galois XNOR LFSR with seed load, all-ones lock-up
// recovery and wrap detection, plus a rejection-sampling front end that
// turns one REQ into one bounded random value on RND/VALID.
// Legal parameter ranges: WIDTH 4..32, OUT_W 1..WIDTH, MAX_TRIES 1..255.
module lfsr_gen
  import lfsr_gen_pkg::*;
#(
  parameter int               WIDTH     = 12,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(default_taps(WIDTH)),
  parameter int               OUT_W     = 8,
  parameter int               MAX_TRIES = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] SEED,
  input  logic             REQ,
  input  logic [OUT_W-1:0] LIMIT,
  output logic [WIDTH-1:0] Q,
  output logic [OUT_W-1:0] RND,
  output logic             VALID,
  output logic             CLAMP,
  output logic             BUSY,
  output logic             WRAP,
  output logic             LOCKUP
);

  localparam logic [WIDTH-1:0] ALL_ONES   = '1;
  localparam logic [7:0]       TRIES_LAST = 8'(MAX_TRIES);

  lfsr_state_e      state_r;
  lfsr_state_e      state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] seed_r;
  logic [OUT_W-1:0] limit_r;
  logic [7:0]       tries_r;
  logic [OUT_W-1:0] cand;
  logic             lock_hit;
  logic             accept;
  logic             last_try;
  logic             do_step;
  logic             fsm_step;
  logic             capture;
  logic             tries_inc;
  logic             deliver_ok;
  logic             deliver_clamp;

  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .q   (Q),
    .nxt (q_nxt)
  );

  // A candidate is the low OUT_W bits of the live state; a captured LIMIT
  // of zero means the full OUT_W range is acceptable.
  assign cand     = Q[OUT_W-1:0];
  assign accept   = (limit_r == '0) || (cand < limit_r);
  assign last_try = ((tries_r + 8'd1) == TRIES_LAST);
  assign lock_hit = (Q == ALL_ONES);
  assign do_step  = EN | fsm_step;
  assign BUSY     = (state_r != ST_IDLE);

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // FSM next state: LOAD aborts a search, DONE always lasts one cycle
  always_comb begin
    state_nxt = state_r;
    unique case (state_r)
      ST_IDLE: begin
        if (REQ && !LOAD) state_nxt = ST_SEARCH;
      end
      ST_SEARCH: begin
        if (LOAD)                  state_nxt = ST_IDLE;
        else if (accept)           state_nxt = ST_DONE;
        else if (last_try)         state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: when to step, capture the request, count or deliver
  always_comb begin
    fsm_step      = 1'b0;
    capture       = 1'b0;
    tries_inc     = 1'b0;
    deliver_ok    = 1'b0;
    deliver_clamp = 1'b0;
    unique case (state_r)
      ST_IDLE: begin
        if (REQ && !LOAD) begin
          capture  = 1'b1;
          fsm_step = 1'b1;
        end
      end
      ST_SEARCH: begin
        if (!LOAD) begin
          if (accept) begin
            deliver_ok = 1'b1;
          end else begin
            fsm_step      = 1'b1;
            tries_inc     = 1'b1;
            deliver_clamp = last_try;
          end
        end
      end
      default: ;
    endcase
  end

  // LFSR state: load beats lock-up recovery beats stepping
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q      <= '0;
      WRAP   <= 1'b0;
      LOCKUP <= 1'b0;
    end else begin
      WRAP   <= 1'b0;
      LOCKUP <= 1'b0;
      if (LOAD) begin
        Q <= SEED;
      end else if (lock_hit) begin
        Q      <= '0;
        LOCKUP <= 1'b1;
      end else if (do_step) begin
        Q    <= q_nxt;
        WRAP <= (q_nxt == seed_r);
      end
    end
  end

  // Seed register remembers the last loaded value for wrap detection
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      seed_r <= '0;
    end else if (LOAD) begin
      seed_r <= SEED;
    end
  end

  // Per-request bound and attempt counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      limit_r <= '0;
      tries_r <= '0;
    end else if (capture) begin
      limit_r <= LIMIT;
      tries_r <= '0;
    end else if (tries_inc) begin
      tries_r <= tries_r + 8'd1;
    end
  end

  // Delivered value, clamp flag and the one-cycle VALID pulse
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RND   <= '0;
      CLAMP <= 1'b0;
      VALID <= 1'b0;
    end else begin
      VALID <= deliver_ok | deliver_clamp;
      if (deliver_ok) begin
        RND   <= cand;
        CLAMP <= 1'b0;
      end else if (deliver_clamp) begin
        RND   <= limit_r - OUT_W'(1);
        CLAMP <= 1'b1;
      end
    end
  end

endmodule
